// File: rtl/delay_line_ctrl.sv
// delay_line_ctrl
//
// Sequencing controller that turns the dual-port sample RAM into a
// programmable-delay circular buffer with a freeze/replay mode. Sample data
// never passes through this block; only RAM control and a dout-aligned valid
// strobe are produced here.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   run        level, 1 = operate, 0 = return to IDLE
//   en         sample strobe, one sample per cycle where high
//   hold       level, 1 = freeze writes and replay the stored window
//   offset     delay in samples, latched on entry to PRIME/RUN
//   wr_en      RAM write enable (registered)
//   rd_en      RAM read enable (registered)
//   wr_addr    RAM write address (registered)
//   rd_addr    RAM read address (registered)
//   out_valid  RAM dout holds a valid delayed sample this cycle
//   state      0 IDLE, 1 PRIME, 2 RUN, 3 HOLD
//
// Configuration:
//   DELAY_LINE_CTRL_REPRIME_EN  when defined, an offset change while in RUN
//                               relatches the delay and re-primes the buffer
//                               from the current write pointer.

module delay_line_ctrl #(
    parameter int ADDRESS_WIDTH = 9
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     run,
    input  logic                     en,
    input  logic                     hold,
    input  logic [ADDRESS_WIDTH-1:0] offset,
    output logic                     wr_en,
    output logic                     rd_en,
    output logic [ADDRESS_WIDTH-1:0] wr_addr,
    output logic [ADDRESS_WIDTH-1:0] rd_addr,
    output logic                     out_valid,
    output logic [1:0]               state
);

    localparam logic [ADDRESS_WIDTH-1:0] ONE = ADDRESS_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] wr_ptr, wr_ptr_d;
    logic [ADDRESS_WIDTH-1:0] rd_ptr, rd_ptr_d;
    logic [ADDRESS_WIDTH-1:0] fill_cnt, fill_cnt_d;
    logic [ADDRESS_WIDTH-1:0] offset_q, offset_d;
    logic                     wr_en_d, rd_en_d;
    logic [ADDRESS_WIDTH-1:0] wr_addr_d, rd_addr_d;

    assign state = state_q;

    // State, pointer and output registers. out_valid is rd_en delayed by one
    // cycle so that a read issued just before a drop of run still completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fill_cnt  <= '0;
            offset_q  <= '0;
            wr_en     <= 1'b0;
            rd_en     <= 1'b0;
            wr_addr   <= '0;
            rd_addr   <= '0;
            out_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr    <= wr_ptr_d;
            rd_ptr    <= rd_ptr_d;
            fill_cnt  <= fill_cnt_d;
            offset_q  <= offset_d;
            wr_en     <= wr_en_d;
            rd_en     <= rd_en_d;
            wr_addr   <= wr_addr_d;
            rd_addr   <= rd_addr_d;
            out_valid <= rd_en;
        end
    end

    // Next state and pointer updates. A strobe arriving on a transition cycle
    // is accounted for under the current state before the transition applies,
    // so the HOLD replay window is anchored on the post-strobe write pointer.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr;
        rd_ptr_d   = rd_ptr;
        fill_cnt_d = fill_cnt;
        offset_d   = offset_q;
        if (!run) begin
            state_d    = IDLE;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            fill_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    offset_d = offset;
                    state_d  = (offset == '0) ? RUN : PRIME;
                end
                PRIME: begin
                    if (en) begin
                        wr_ptr_d   = wr_ptr + ONE;
                        fill_cnt_d = fill_cnt + ONE;
                        if (fill_cnt_d == offset_q) begin
                            state_d = RUN;
                        end
                    end
                end
                RUN: begin
                    if (en) begin
                        wr_ptr_d = wr_ptr + ONE;
                    end
`ifdef DELAY_LINE_CTRL_REPRIME_EN
                    if (offset != offset_q) begin
                        offset_d   = offset;
                        fill_cnt_d = '0;
                        state_d    = (offset == '0) ? RUN : PRIME;
                    end else if (hold) begin
                        state_d  = HOLD;
                        rd_ptr_d = wr_ptr_d - offset_q;
                    end
`else
                    if (hold) begin
                        state_d  = HOLD;
                        rd_ptr_d = wr_ptr_d - offset_q;
                    end
`endif
                end
                HOLD: begin
                    // Loop back to the oldest sample of the window after
                    // reading the newest one (wr_ptr-1).
                    if (en) begin
                        rd_ptr_d = (rd_ptr == wr_ptr - ONE) ? (wr_ptr - offset_q)
                                                            : (rd_ptr + ONE);
                    end
                    if (!hold) begin
                        state_d = RUN;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // RAM command generation. Addresses keep their last value between
    // strobes and are cleared whenever the controller falls back to IDLE.
    always_comb begin
        wr_en_d   = 1'b0;
        rd_en_d   = 1'b0;
        wr_addr_d = wr_addr;
        rd_addr_d = rd_addr;
        if (!run) begin
            wr_addr_d = '0;
            rd_addr_d = '0;
        end else begin
            case (state_q)
                PRIME: begin
                    if (en) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = wr_ptr;
                    end
                end
                RUN: begin
                    if (en) begin
                        wr_en_d   = 1'b1;
                        rd_en_d   = 1'b1;
                        wr_addr_d = wr_ptr;
                        rd_addr_d = wr_ptr - offset_q;
                    end
                end
                HOLD: begin
                    if (en) begin
                        rd_en_d   = 1'b1;
                        rd_addr_d = rd_ptr;
                    end
                end
                default: begin
                    wr_en_d = 1'b0;
                    rd_en_d = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_delay_line_ctrl.sv
// tb_delay_line_ctrl
//
// Self-checking bench for delay_line_ctrl with ADDRESS_WIDTH=4. The reference
// model tracks how many samples have been written since leaving IDLE, the
// active delay and a replay position, and derives the expected RAM commands
// from those counts.

module tb_delay_line_ctrl;

    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          run = 1'b0;
    logic          en = 1'b0;
    logic          hold = 1'b0;
    logic [AW-1:0] offset = '0;
    logic          wr_en, rd_en, out_valid;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [1:0]    state;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;

    // Reference model state
    logic [1:0]    m_state = 2'd0;
    int            m_writes = 0;
    int            m_delay = 0;
    int            m_primed = 0;
    int            m_k = 0;
    logic          e_wr_en = 1'b0;
    logic          e_rd_en = 1'b0;
    logic          e_out_valid = 1'b0;
    logic [AW-1:0] e_wr_addr = '0;
    logic [AW-1:0] e_rd_addr = '0;

    always #5 clk = ~clk;

    delay_line_ctrl #(.ADDRESS_WIDTH(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .en        (en),
        .hold      (hold),
        .offset    (offset),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .wr_addr   (wr_addr),
        .rd_addr   (rd_addr),
        .out_valid (out_valid),
        .state     (state)
    );

    function automatic logic [AW-1:0] addr_of(input int n);
        logic [31:0] v;
        v = n;
        return v[AW-1:0];
    endfunction

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        int len;
        if (rst) begin
            m_state = 2'd0; m_writes = 0; m_delay = 0; m_primed = 0; m_k = 0;
            e_wr_en = 1'b0; e_rd_en = 1'b0; e_out_valid = 1'b0;
            e_wr_addr = '0; e_rd_addr = '0;
            return;
        end
        e_out_valid = e_rd_en;
        e_wr_en = 1'b0;
        e_rd_en = 1'b0;
        len = (m_delay == 0) ? DEPTH : m_delay;
        if (!run) begin
            m_state = 2'd0; m_writes = 0; m_primed = 0; m_k = 0;
            e_wr_addr = '0; e_rd_addr = '0;
        end else begin
            case (m_state)
                2'd0: begin
                    m_delay  = int'(offset);
                    m_primed = 0;
                    m_state  = (offset == '0) ? 2'd2 : 2'd1;
                end
                2'd1: begin
                    if (en) begin
                        e_wr_en = 1'b1;
                        e_wr_addr = addr_of(m_writes);
                        m_writes++;
                        m_primed++;
                        if (m_primed == m_delay) m_state = 2'd2;
                    end
                end
                2'd2: begin
                    if (en) begin
                        e_wr_en = 1'b1;
                        e_rd_en = 1'b1;
                        e_wr_addr = addr_of(m_writes);
                        e_rd_addr = addr_of(m_writes - m_delay);
                        m_writes++;
                    end
`ifdef DELAY_LINE_CTRL_REPRIME_EN
                    if (int'(offset) != m_delay) begin
                        m_delay  = int'(offset);
                        m_primed = 0;
                        m_state  = (offset == '0) ? 2'd2 : 2'd1;
                    end else if (hold) begin
                        m_state = 2'd3;
                        m_k = 0;
                    end
`else
                    if (hold) begin
                        m_state = 2'd3;
                        m_k = 0;
                    end
`endif
                end
                default: begin
                    if (en) begin
                        e_rd_en = 1'b1;
                        e_rd_addr = addr_of(m_writes - len + m_k);
                        m_k = (m_k + 1) % len;
                    end
                    if (!hold) m_state = 2'd2;
                end
            endcase
        end
    endtask

    // Drive one cycle of inputs on the falling edge, then settle after the
    // rising edge so outputs can be sampled.
    task automatic step(input logic r, input logic ru, input logic e,
                        input logic h, input logic [AW-1:0] o);
        @(negedge clk);
        rst = r; run = ru; en = e; hold = h; offset = o;
        model_step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'd3);
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd3);
        step(1'b0, 1'b1, 1'b1, 1'b0, 4'd3);
        step(1'b0, 1'b1, 1'b1, 1'b0, 4'd3);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b1, 1'b0, 4'd3);
            tests_run++;
            if ({wr_en, rd_en, out_valid, state, wr_addr, rd_addr} !== 13'd0) begin
                tests_failed++;
                $display("[TB] FAIL reset cyc%0d: got we=%b re=%b ov=%b st=%0d wa=%0d ra=%0d, want all 0",
                         cyc, wr_en, rd_en, out_valid, state, wr_addr, rd_addr);
            end
        end
    endtask

    task automatic test_prime_delay();
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd3);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0, 4'd3);
            tests_run++;
            if ({wr_en, rd_en, out_valid, state, (e_wr_en ? wr_addr : 4'd0), (e_rd_en ? rd_addr : 4'd0)} !==
                {e_wr_en, e_rd_en, e_out_valid, m_state, (e_wr_en ? e_wr_addr : 4'd0), (e_rd_en ? e_rd_addr : 4'd0)}) begin
                tests_failed++;
                $display("[TB] FAIL prime cyc%0d: got we=%b re=%b ov=%b st=%0d wa=%0d ra=%0d, want we=%b re=%b ov=%b st=%0d wa=%0d ra=%0d",
                         cyc, wr_en, rd_en, out_valid, state, wr_addr, rd_addr,
                         e_wr_en, e_rd_en, e_out_valid, m_state, e_wr_addr, e_rd_addr);
            end
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0, 4'd3);
            tests_run++;
            if ({wr_en, rd_en, out_valid, state, wr_addr, rd_addr} !==
                {1'b1, 1'b1, 1'b1, 2'd2, e_wr_addr, e_rd_addr}) begin
                tests_failed++;
                $display("[TB] FAIL wrap cyc%0d: got we=%b re=%b ov=%b st=%0d wa=%0d ra=%0d, want 1 1 1 2 wa=%0d ra=%0d",
                         cyc, wr_en, rd_en, out_valid, state, wr_addr, rd_addr, e_wr_addr, e_rd_addr);
            end
        end
    endtask

    task automatic test_hold();
        logic [AW-1:0] replay [7];
        replay = '{4'd1, 4'd2, 4'd3, 4'd1, 4'd2, 4'd3, 4'd1};
        step(1'b0, 1'b1, 1'b0, 1'b1, 4'd3);
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 1'b1, 1'b1, 1'b1, 4'd3);
            tests_run++;
            if ({wr_en, rd_en, state, rd_addr} !== {1'b0, 1'b1, 2'd3, replay[i]} ||
                rd_addr !== e_rd_addr || out_valid !== e_out_valid) begin
                tests_failed++;
                $display("[TB] FAIL hold cyc%0d: got we=%b re=%b ov=%b st=%0d ra=%0d, want we=0 re=1 ov=%b st=3 ra=%0d",
                         cyc, wr_en, rd_en, out_valid, state, rd_addr, e_out_valid, replay[i]);
            end
        end
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd3);
        step(1'b0, 1'b1, 1'b1, 1'b0, 4'd3);
        tests_run++;
        if ({wr_en, rd_en, state, wr_addr, rd_addr} !== {1'b1, 1'b1, 2'd2, 4'd4, 4'd1}) begin
            tests_failed++;
            $display("[TB] FAIL hold_release: got we=%b re=%b st=%0d wa=%0d ra=%0d, want we=1 re=1 st=2 wa=4 ra=1",
                     wr_en, rd_en, state, wr_addr, rd_addr);
        end
    endtask

    task automatic test_abort_gaps();
        step(1'b0, 1'b0, 1'b0, 1'b0, 4'd3);
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd3);
        step(1'b0, 1'b1, 1'b1, 1'b0, 4'd3);
        step(1'b0, 1'b1, 1'b1, 1'b0, 4'd3);
        step(1'b0, 1'b0, 1'b1, 1'b0, 4'd3);
        tests_run++;
        if ({wr_en, rd_en, state} !== {1'b0, 1'b0, 2'd0}) begin
            tests_failed++;
            $display("[TB] FAIL abort: got we=%b re=%b st=%0d, want we=0 re=0 st=0", wr_en, rd_en, state);
        end
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd3);
        for (int i = 0; i < 18; i++) begin
            step(1'b0, 1'b1, (i % 3) == 0, 1'b0, 4'd3);
            tests_run++;
            if ({wr_en, rd_en, out_valid, state, (e_wr_en ? wr_addr : 4'd0), (e_rd_en ? rd_addr : 4'd0)} !==
                {e_wr_en, e_rd_en, e_out_valid, m_state, (e_wr_en ? e_wr_addr : 4'd0), (e_rd_en ? e_rd_addr : 4'd0)}) begin
                tests_failed++;
                $display("[TB] FAIL gaps cyc%0d: got we=%b re=%b ov=%b st=%0d wa=%0d ra=%0d, want we=%b re=%b ov=%b st=%0d wa=%0d ra=%0d",
                         cyc, wr_en, rd_en, out_valid, state, wr_addr, rd_addr,
                         e_wr_en, e_rd_en, e_out_valid, m_state, e_wr_addr, e_rd_addr);
            end
            if (i == 0) begin
                tests_run++;
                if (wr_addr !== 4'd0 || wr_en !== 1'b1) begin
                    tests_failed++;
                    $display("[TB] FAIL reprime_from_zero: got we=%b wa=%0d, want we=1 wa=0", wr_en, wr_addr);
                end
            end
        end
    endtask

    task automatic test_reprime();
        int exp_delay;
`ifdef DELAY_LINE_CTRL_REPRIME_EN
        exp_delay = 5;
`else
        exp_delay = 3;
`endif
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd5);
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0, 4'd5);
            tests_run++;
            if ({wr_en, rd_en, out_valid, state, (e_wr_en ? wr_addr : 4'd0), (e_rd_en ? rd_addr : 4'd0)} !==
                {e_wr_en, e_rd_en, e_out_valid, m_state, (e_wr_en ? e_wr_addr : 4'd0), (e_rd_en ? e_rd_addr : 4'd0)}) begin
                tests_failed++;
                $display("[TB] FAIL reprime cyc%0d: got we=%b re=%b ov=%b st=%0d wa=%0d ra=%0d, want we=%b re=%b ov=%b st=%0d wa=%0d ra=%0d",
                         cyc, wr_en, rd_en, out_valid, state, wr_addr, rd_addr,
                         e_wr_en, e_rd_en, e_out_valid, m_state, e_wr_addr, e_rd_addr);
            end
        end
        tests_run++;
        if (rd_en !== 1'b1 || rd_addr !== addr_of(int'(wr_addr) - exp_delay)) begin
            tests_failed++;
            $display("[TB] FAIL reprime_delay: got re=%b wa=%0d ra=%0d, want re=1 delay %0d",
                     rd_en, wr_addr, rd_addr, exp_delay);
        end
    endtask

    task automatic test_random();
        logic          r_run, r_hold;
        logic [AW-1:0] r_off;
        r_run = 1'b1; r_hold = 1'b0; r_off = 4'd6;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 59) == 0) r_run = ~r_run;
            if ($urandom_range(0, 9) == 0) r_hold = ~r_hold;
            if ($urandom_range(0, 39) == 0) r_off = ($urandom_range(0, 5) == 0) ? 4'd0 : AW'($urandom_range(1, 15));
            step($urandom_range(0, 299) == 0, r_run || ($urandom_range(0, 3) == 0),
                 $urandom_range(0, 3) != 0, r_hold, r_off);
            tests_run++;
            if ({wr_en, rd_en, out_valid, state, (e_wr_en ? wr_addr : 4'd0), (e_rd_en ? rd_addr : 4'd0)} !==
                {e_wr_en, e_rd_en, e_out_valid, m_state, (e_wr_en ? e_wr_addr : 4'd0), (e_rd_en ? e_rd_addr : 4'd0)}) begin
                tests_failed++;
                $display("[TB] FAIL random cyc%0d: got we=%b re=%b ov=%b st=%0d wa=%0d ra=%0d, want we=%b re=%b ov=%b st=%0d wa=%0d ra=%0d",
                         cyc, wr_en, rd_en, out_valid, state, wr_addr, rd_addr,
                         e_wr_en, e_rd_en, e_out_valid, m_state, e_wr_addr, e_rd_addr);
            end
        end
    endtask

    initial begin
        test_reset();
        test_prime_delay();
        test_wrap();
        test_hold();
        test_abort_gaps();
        test_reprime();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/delay_line_ctrl.md
# delay_line_ctrl

Sequencing controller for the dual-port sample RAM (`dualram`), turning it into a programmable-delay circular buffer with a freeze/replay mode. It sits between the sample source and the RAM in the signal-generator datapath. It generates all RAM control signals and a `dout`-aligned valid strobe. The controller never touches sample data: `din` goes straight to the RAM and `dout` comes straight from it.

## Interface
- `ADDRESS_WIDTH`, default 9: RAM address width; buffer depth is 2^ADDRESS_WIDTH.
- `clk`  in  1: clock; all logic on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `run`  in  1: level; 1 = operate, 0 = return to IDLE.
- `en`  in  1: sample strobe; one sample per cycle where `en`=1.
- `hold`  in  1: level; 1 = freeze writes and replay stored window.
- `offset`  in  ADDRESS_WIDTH: delay in samples; latched on entry to PRIME.
- `wr_en`  out  1: RAM write enable, registered.
- `rd_en`  out  1: RAM read enable, registered.
- `wr_addr`  out  ADDRESS_WIDTH: RAM write address, registered.
- `rd_addr`  out  ADDRESS_WIDTH: RAM read address, registered.
- `out_valid`  out  1: RAM `dout` holds a valid delayed sample this cycle.
- `state`  out  2: 0 IDLE, 1 PRIME, 2 RUN, 3 HOLD.

## Operation
- Internal registers: `wr_ptr`, `rd_ptr`, `fill_cnt` (all ADDRESS_WIDTH bits wide), `offset_q`.
- All pointer arithmetic is modulo 2^ADDRESS_WIDTH (plain truncation).
- IDLE:
  - `wr_ptr`, `rd_ptr` and `fill_cnt` are 0. No RAM access.
  - When `run`=1, latch `offset_q`=`offset`.
  - If `offset`=0, go directly to RUN. Otherwise go to PRIME.
- PRIME (runs for `offset_q` strobes):
  - Each `en`: write at `wr_ptr`, then `wr_ptr`+1 and `fill_cnt`+1. No read.
  - When the strobe that makes `fill_cnt`==`offset_q` is issued, go to RUN.
  - `hold` is ignored in PRIME.
- RUN:
  - Each `en`: write at `wr_ptr` and read at `wr_ptr`−`offset_q` in the same cycle. Then `wr_ptr`+1.
  - The read returns the sample written `offset_q` strobes earlier.
  - `offset_q`=0: read and write hit the same address. The RAM is read-before-write, so the read returns the contents from 2^ADDRESS_WIDTH strobes earlier (full-depth delay).
  - `hold`=1 → go to HOLD, with `rd_ptr`=`wr_ptr`−`offset_q`.
- HOLD:
  - `wr_en` is never asserted; `wr_ptr` is frozen.
  - Each `en`: read at `rd_ptr`. If `rd_ptr`==`wr_ptr`−1, the next `rd_ptr` is `wr_ptr`−`offset_q`; otherwise `rd_ptr`+1.
  - This replays the last `offset_q` samples in a loop. For `offset_q`=0, the loop covers the whole buffer.
  - `hold`=0 → go to RUN; normal RUN addressing resumes from the frozen `wr_ptr`.
- `run`=0 in any state → IDLE on the next edge. Outputs go 0 and pointers clear.
- Priority: `rst` > `run`=0 > transitions driven by `hold` or `fill_cnt` > normal strobe handling.
- A strobe in the same cycle as a state transition is processed under the pre-transition state.

## Timing
- Reset: `wr_en`, `rd_en`, `wr_addr`, `rd_addr`, `out_valid` are 0; `state` is IDLE (0); internal registers are 0.
- `en` sampled high at edge N → `wr_en`/`rd_en`/addresses valid for exactly the cycle after N (N+1), then deassert unless `en` is high again.
- RAM `dout` is valid at N+2; `out_valid` is asserted for exactly that cycle. `out_valid` is `rd_en` delayed by one cycle.
- Back-to-back `en` every cycle is supported at full throughput. Gaps in `en` pause the controller with no side effects.
- `state` is registered and updates on the same edge as the pointers.
- In-flight `out_valid` from the last strobe before an IDLE transition still fires on the following cycle, unless `rst` is asserted.

## Configuration
- `DELAY_LINE_CTRL_REPRIME_EN` defined:
  - In RUN, any cycle with `offset` ≠ `offset_q` relatches `offset_q`, clears `fill_cnt`, and enters PRIME.
  - `wr_ptr` is kept. `out_valid` stays low until the new prime completes.
  - A new `offset` of 0 goes to RUN instead.
- `DELAY_LINE_CTRL_REPRIME_EN` undefined: `offset` is ignored outside IDLE→PRIME/RUN entry; the delay changes only after a `run` 0→1 cycle.

## Test plan
- Reset: assert `rst` with `run`=1 and `en`=1 → all outputs 0 and `state`=0 on the cycle after; held 0 while `rst`=1.
- Prime/delay (ADDRESS_WIDTH=4, `offset`=3, `en` every cycle, `din`=0,1,2,…) → first 3 strobes give `wr_en` only, `state` goes 1→2; then `out_valid` every cycle with `dout`=`din`−3 (0,1,2,…).
- Wrap (same setup, 20 strobes) → `wr_addr` runs …15,0,1…; `rd_addr` is `wr_addr`−3 mod 16 (13,14,15,0…); no gap in `out_valid`.
- Hold (after 20 strobes: `wr_ptr`=4, `offset`=3; `hold`=1 for 7 strobes) → `wr_en`=0; `rd_addr` is 1,2,3,1,2,3,1. Releasing `hold` gives `wr_addr`=4, `rd_addr`=1.
- Abort: `run`=0 after the 2nd PRIME strobe → IDLE; next `run`=1 primes from `wr_addr`=0 again. With `en` gaps of 2 cycles, addresses advance only on strobes.
- Reprime: change `offset` 3→5 in RUN → with macro, `state`=1 for 5 strobes with no `out_valid`, then delay 5; without macro, delay stays 3.
